// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Multi-cycle instruction sequencer. It owns the program counter's control
// inputs and steps every instruction through FETCH / DECODE / EXEC / WB. In WB
// it issues exactly one PC action: increment, relative branch or absolute jump.
// After reset it spends one cycle in RST and loads RESET_VEC into the PC.
//
// Optional feature, enabled by defining the macro PC_TRAP_EN:
//   adds input trap_req and output epc. A trap latched at the end of EXEC has
//   top priority in WB. It loads TRAP_VEC, saves pc_cur + 1 in epc and
//   overrides a halt for that instruction.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   rst          in   1       synchronous, active-high reset
//   mem_ready    in   1       instruction memory data valid for the current fetch
//   stall        in   1       hold the sequencer in DECODE / EXEC
//   branch_taken in   1       conditional branch taken (sampled at EXEC exit)
//   branch_off   in   WORD_W  signed offset relative to the next instruction
//   jump_req     in   1       absolute jump (sampled at EXEC exit)
//   jump_target  in   WORD_W  jump destination
//   halt         in   1       halt after this instruction (sampled at EXEC exit)
//   trap_req     in   1       trap request, PC_TRAP_EN only (sampled at EXEC exit)
//   pc_cur       in   WORD_W  current PC value
//   pc_load      out  1       PC load strobe
//   pc_offset    out  1       PC add strobe
//   pc_data      out  WORD_W  PC load value or addend
//   fetch_req    out  1       instruction fetch request
//   ir_load      out  1       instruction register capture strobe
//   timer        out  4       one-hot phase: bit0 FETCH, bit1 DECODE, bit2 EXEC, bit3 WB
//   halted       out  1       sequencer halted
//   epc          out  WORD_W  PC + 1 of the trapping instruction, PC_TRAP_EN only
//   retired      out  16      retired instruction count, wraps at 16 bits
//
// All outputs come straight from flops. Their next values are derived from the
// next state, so each output is aligned with the state it describes.

module pc_sequencer #(
    parameter int unsigned       WORD_W    = 16,
    parameter logic [WORD_W-1:0] RESET_VEC = 16'h0000,
    parameter logic [WORD_W-1:0] TRAP_VEC  = 16'h0004
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ready,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_off,
    input  logic              jump_req,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              halt,
`ifdef PC_TRAP_EN
    input  logic              trap_req,
    output logic [WORD_W-1:0] epc,
`endif
    input  logic [WORD_W-1:0] pc_cur,
    output logic              pc_load,
    output logic              pc_offset,
    output logic [WORD_W-1:0] pc_data,
    output logic              fetch_req,
    output logic              ir_load,
    output logic [3:0]        timer,
    output logic              halted,
    output logic [15:0]       retired
);

    typedef enum logic [2:0] {
        StRst,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalted
    } state_e;

    state_e state_q, state_d;

    // Set while rst is held. It marks the single post-reset cycle in which
    // RST issues the RESET_VEC load.
    logic boot_q;

    // Control captured when EXEC completes. It decides where WB goes next.
    logic halt_q, halt_d;
    logic trap_hit;

    logic              pc_load_q, pc_load_d;
    logic              pc_offset_q, pc_offset_d;
    logic [WORD_W-1:0] pc_data_q, pc_data_d;
    logic              fetch_req_q, fetch_req_d;
    logic              ir_load_q, ir_load_d;
    logic [3:0]        timer_q, timer_d;
    logic              halted_q, halted_d;
    logic [15:0]       retired_q, retired_d;

    logic exec_done;
    logic rst_pulse;

    assign exec_done = (state_q == StExec) && !stall;
    assign rst_pulse = (state_q == StRst) && boot_q;

`ifdef PC_TRAP_EN
    logic              trap_q, trap_d;
    logic [WORD_W-1:0] epc_q, epc_d;

    assign trap_hit = trap_q;
    assign epc      = epc_q;
`else
    assign trap_hit = 1'b0;

    // pc_cur only feeds epc, which exists only with the trap feature.
    logic unused_pc_cur;
    assign unused_pc_cur = ^pc_cur;
`endif

    // ------------------------------------------------------------------
    // State register (also holds every registered output and latch)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRst;
            boot_q      <= 1'b1;
            halt_q      <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_offset_q <= 1'b0;
            pc_data_q   <= '0;
            fetch_req_q <= 1'b0;
            ir_load_q   <= 1'b0;
            timer_q     <= 4'b0000;
            halted_q    <= 1'b0;
            retired_q   <= 16'h0000;
`ifdef PC_TRAP_EN
            trap_q      <= 1'b0;
            epc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            boot_q      <= 1'b0;
            halt_q      <= halt_d;
            pc_load_q   <= pc_load_d;
            pc_offset_q <= pc_offset_d;
            pc_data_q   <= pc_data_d;
            fetch_req_q <= fetch_req_d;
            ir_load_q   <= ir_load_d;
            timer_q     <= timer_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
`ifdef PC_TRAP_EN
            trap_q      <= trap_d;
            epc_q       <= epc_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Stay one more cycle after rst drops to issue the RESET_VEC load.
            StRst:    state_d = boot_q ? StRst : StFetch;
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: if (!stall) state_d = StExec;
            StExec:   if (!stall) state_d = StWb;
            // A trap overrides a halt in the same instruction.
            StWb:     state_d = (halt_q && !trap_hit) ? StHalted : StFetch;
            StHalted: state_d = StHalted;
            default:  state_d = StRst;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / latch next values
    // ------------------------------------------------------------------
    always_comb begin
        pc_load_d   = 1'b0;
        pc_offset_d = 1'b0;
        pc_data_d   = '0;
        fetch_req_d = (state_d == StFetch);
        ir_load_d   = (state_q == StFetch) && mem_ready;
        halted_d    = (state_d == StHalted);
        halt_d      = halt_q;
        retired_d   = retired_q;

        case (state_d)
            StFetch:  timer_d = 4'b0001;
            StDecode: timer_d = 4'b0010;
            StExec:   timer_d = 4'b0100;
            StWb:     timer_d = 4'b1000;
            default:  timer_d = 4'b0000;
        endcase

        // The WB action is decided from live EXEC inputs at the EXEC exit edge.
        // It is captured directly into the strobe and data flops, so only the
        // halt/trap bits need separate latches.
        if (rst_pulse) begin
            pc_load_d = 1'b1;
            pc_data_d = RESET_VEC;
        end else if (exec_done) begin
            halt_d = halt;
`ifdef PC_TRAP_EN
            if (trap_req) begin
                pc_load_d = 1'b1;
                pc_data_d = TRAP_VEC;
            end else
`endif
            if (jump_req) begin
                pc_load_d = 1'b1;
                pc_data_d = jump_target;
            end else if (branch_taken) begin
                pc_offset_d = 1'b1;
                pc_data_d   = branch_off + WORD_W'(1);
            end else begin
                pc_offset_d = 1'b1;
                pc_data_d   = WORD_W'(1);
            end
        end

        // An instruction retires as its PC update commits at the WB exit edge.
        if (state_q == StWb) begin
            retired_d = retired_q + 16'd1;
        end
    end

`ifdef PC_TRAP_EN
    always_comb begin
        trap_d = trap_q;
        epc_d  = epc_q;
        if (exec_done) begin
            trap_d = trap_req;
        end
        if ((state_q == StWb) && trap_q) begin
            epc_d = pc_cur + WORD_W'(1);
        end
    end
`endif

    assign pc_load   = pc_load_q;
    assign pc_offset = pc_offset_q;
    assign pc_data   = pc_data_q;
    assign fetch_req = fetch_req_q;
    assign ir_load   = ir_load_q;
    assign timer     = timer_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle instruction sequencer that owns the program counter's control inputs (load, offset, data).
- Steps each instruction through FETCH/DECODE/EXEC/WB and drives the one-hot timer phase.
- Selects the next-PC action (increment, relative branch, absolute jump) and emits it as a single-cycle pulse in WB.
- Sits between the control decoder / ALU branch logic and the PC register; it is the only driver of the PC controls.

Parameters:
- WORD_W, 16, datapath and PC width.
- RESET_VEC, 16'h0000, PC value loaded after reset.
- TRAP_VEC, 16'h0004, trap entry address (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_ready  in  1  instruction memory has valid data for the current fetch.
- stall  in  1  hold the sequencer in DECODE/EXEC.
- branch_taken  in  1  conditional branch resolved taken; valid in EXEC.
- branch_off  in  WORD_W  signed word offset relative to the next instruction; valid in EXEC.
- jump_req  in  1  absolute jump; valid in EXEC.
- jump_target  in  WORD_W  jump destination; valid in EXEC.
- halt  in  1  halt after the current instruction; valid in EXEC.
- pc_cur  in  WORD_W  current PC value.
- pc_load  out  1  PC load strobe.
- pc_offset  out  1  PC add strobe.
- pc_data  out  WORD_W  PC load value or addend.
- fetch_req  out  1  instruction fetch request.
- ir_load  out  1  instruction register capture strobe.
- timer  out  4  one-hot phase: bit0 FETCH, bit1 DECODE, bit2 EXEC, bit3 WB.
- halted  out  1  sequencer is halted.
- retired  out  16  count of retired instructions; wraps at 0xFFFF->0x0000.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = RST.
  - pc_load = pc_offset = 0, pc_data = 0.
  - fetch_req = ir_load = 0, timer = 4'b0000, halted = 0, retired = 0.
- rst takes priority over every other input in every state, including mid-instruction and HALTED; any pending PC pulse is dropped.
- States: RST, FETCH, DECODE, EXEC, WB, HALTED.
- RST:
  - Lasts 1 cycle after rst deasserts.
  - Drives pc_load = 1 and pc_data = RESET_VEC for exactly that cycle, then goes to FETCH.
- FETCH:
  - timer = 0001 and fetch_req = 1.
  - Waits indefinitely for mem_ready.
  - When mem_ready = 1: ir_load pulses for 1 cycle, fetch_req drops, and the next state is DECODE.
  - FETCH with mem_ready already high lasts exactly 1 cycle.
- DECODE:
  - timer = 0010; lasts 1 cycle unless stall.
  - Goes to EXEC.
- EXEC:
  - timer = 0100; lasts 1 cycle unless stall.
  - At the exit edge, latches jump_req, jump_target, branch_taken, branch_off and halt.
  - Goes to WB.
- Stall: while stall = 1 in DECODE or EXEC, state and all latches hold and no strobe is emitted. stall is ignored in FETCH and WB.
- WB:
  - timer = 1000; lasts exactly 1 cycle and emits exactly one PC action.
  - Jump latched: pc_load = 1, pc_data = jump_target.
  - Else branch taken: pc_offset = 1, pc_data = 1 + branch_off, modulo 2^WORD_W.
  - Else: pc_offset = 1, pc_data = 1.
  - Jump beats branch when both are latched.
  - retired increments by 1.
  - Next state is HALTED if halt was latched, else FETCH.
- HALTED:
  - timer = 0000, halted = 1, no strobes.
  - Exits only via rst.
- Strobes are never asserted together and are 0 in all states not listed above.
- Minimum instruction latency is 4 cycles (FETCH..WB).

Optional Feature:
- Macro: PC_TRAP_EN.
- With the macro defined:
  - Adds input trap_req (1) and output epc (WORD_W, reset 0).
  - trap_req is sampled at the EXEC exit edge, same as the other EXEC inputs.
  - If latched, it has top priority in WB: pc_load = 1, pc_data = TRAP_VEC, epc <= pc_cur + 1.
  - retired still increments.
  - A latched halt is ignored for that instruction; the next state is FETCH.
- Without the macro: the trap_req and epc ports do not exist, and behaviour is exactly as described above.

Test Plan:
- Reset:
  - Stimulus: assert rst for 3 cycles, then release, with mem_ready = 1.
  - Response: pc_load pulses once with pc_data = 0x0000; the next cycle timer = 0001 and fetch_req = 1.
- Sequential run:
  - Stimulus: mem_ready tied 1, 3 instructions, no branches.
  - Response: timer cycles 1,2,4,8 every 4 cycles; three pc_offset pulses with pc_data = 0x0001; retired = 3.
- Branch and jump:
  - Stimulus: branch_taken with branch_off = 0xFFFE.
  - Response: WB pc_offset = 1 with pc_data = 0xFFFF.
  - Stimulus: jump_req = 1 with jump_target = 0x0040 together with branch_taken = 1.
  - Response: only pc_load pulses, with pc_data = 0x0040.
- Wait and stall:
  - Stimulus: mem_ready held low for 5 cycles.
  - Response: FETCH lasts 6 cycles and ir_load pulses once.
  - Stimulus: stall high for 2 cycles in EXEC.
  - Response: EXEC lasts 3 cycles with no strobes.
- Halt and mid-operation reset:
  - Stimulus: halt = 1 in EXEC.
  - Response: WB increment, then halted = 1 and timer = 0 forever.
  - Stimulus: rst in EXEC.
  - Response: no WB strobe; RST pulse loads 0x0000; retired = 0.
- Trap (PC_TRAP_EN defined):
  - Stimulus: trap_req = 1 in EXEC with pc_cur = 0x0010 and jump_req = 1.
  - Response: pc_load with pc_data = 0x0004; epc = 0x0011.
